// File: rtl/axi_stream_demux_pkg.sv
// Shared types and constants for the 1:8 AXI-stream demultiplexer.
// Optional build macro: AXIS_DEMUX_DEST_ROUTE_EN (routes on tdest[2:0] instead of address).
package axi_stream_demux_pkg;

    localparam int N_OUTPUTS      = 8;
    localparam int SEL_WIDTH      = 3;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_DEST_WIDTH = 8;
    localparam int DEF_USER_WIDTH = 8;

    // Packet tracking: IDLE samples a fresh select, IN_PKT holds it until tlast
    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } demux_state_t;

    // One beat as it travels through the output/skid registers, tagged with its select
    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data;
        logic [DEF_DEST_WIDTH-1:0] dest;
        logic [DEF_USER_WIDTH-1:0] user;
        logic                      tlast;
        logic [SEL_WIDTH-1:0]      sel;
    } demux_beat_t;

endpackage

// File: rtl/axi_stream_skid_buffer.sv
// Two-entry register slice (output register + skid register) carrying a beat struct.
// in_ready is a flop, so there is no combinational path from out_ready to in_ready.
// Handshake: a transfer happens on a rising edge where valid & ready are both 1;
// out_valid never drops and out_beat never changes until out_ready is seen.
module axi_stream_skid_buffer
    import axi_stream_demux_pkg::*;
#(
    parameter type beat_t = demux_beat_t
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  in_valid,
    input  beat_t in_beat,
    output logic  in_ready,
    output logic  out_valid,
    output beat_t out_beat,
    input  logic  out_ready
);

    logic  out_valid_q, out_valid_d;
    beat_t out_beat_q, out_beat_d;
    logic  skid_valid_q, skid_valid_d;
    beat_t skid_beat_q, skid_beat_d;
    logic  in_ready_q, in_ready_d;
    logic  accept;

    // Next-state of both entries; the skid only fills when the output is stalled
    always_comb begin
        out_valid_d  = out_valid_q;
        out_beat_d   = out_beat_q;
        skid_valid_d = skid_valid_q;
        skid_beat_d  = skid_beat_q;
        accept       = in_valid & in_ready_q;
        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                // in_ready is low while the skid is full, so no accept can collide here
                out_beat_d   = skid_beat_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_beat_d  = in_beat;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_beat_d  = in_beat;
            skid_valid_d = 1'b1;
        end
        in_ready_d = ~skid_valid_d;
    end

    // Register both entries and the registered ready
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_beat_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_beat_q  <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_beat_q   <= out_beat_d;
            skid_valid_q <= skid_valid_d;
            skid_beat_q  <= skid_beat_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_beat  = out_beat_q;

endmodule

// File: rtl/axi_stream_demux_8.sv
// 1:8 packet-aware AXI-stream demultiplexer with registered, skid-buffered output.
// Destination is latched on the first beat of a packet and held through tlast.
// Optional build macro: AXIS_DEMUX_DEST_ROUTE_EN selects from stream_in_dest[2:0]
// instead of the address port (address then stays in the port list, unused).
module axi_stream_demux_8
    import axi_stream_demux_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic [DATA_WIDTH-1:0] stream_in_data,
    input  logic [DEST_WIDTH-1:0] stream_in_dest,
    input  logic [USER_WIDTH-1:0] stream_in_user,
    input  logic                  stream_in_tlast,
    input  logic                  stream_in_valid,
    output logic                  stream_in_ready,
    output logic [DATA_WIDTH-1:0] stream_out_1_data, stream_out_2_data, stream_out_3_data, stream_out_4_data,
    output logic [DATA_WIDTH-1:0] stream_out_5_data, stream_out_6_data, stream_out_7_data, stream_out_8_data,
    output logic [DEST_WIDTH-1:0] stream_out_1_dest, stream_out_2_dest, stream_out_3_dest, stream_out_4_dest,
    output logic [DEST_WIDTH-1:0] stream_out_5_dest, stream_out_6_dest, stream_out_7_dest, stream_out_8_dest,
    output logic [USER_WIDTH-1:0] stream_out_1_user, stream_out_2_user, stream_out_3_user, stream_out_4_user,
    output logic [USER_WIDTH-1:0] stream_out_5_user, stream_out_6_user, stream_out_7_user, stream_out_8_user,
    output logic                  stream_out_1_tlast, stream_out_2_tlast, stream_out_3_tlast, stream_out_4_tlast,
    output logic                  stream_out_5_tlast, stream_out_6_tlast, stream_out_7_tlast, stream_out_8_tlast,
    output logic                  stream_out_1_valid, stream_out_2_valid, stream_out_3_valid, stream_out_4_valid,
    output logic                  stream_out_5_valid, stream_out_6_valid, stream_out_7_valid, stream_out_8_valid,
    input  logic                  stream_out_1_ready, stream_out_2_ready, stream_out_3_ready, stream_out_4_ready,
    input  logic                  stream_out_5_ready, stream_out_6_ready, stream_out_7_ready, stream_out_8_ready,
    output logic                  debug_state
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic [USER_WIDTH-1:0] user;
        logic                  tlast;
        logic [SEL_WIDTH-1:0]  sel;
    } beat_t;

    demux_state_t         state_q, state_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic [SEL_WIDTH-1:0] start_sel;
    logic [SEL_WIDTH-1:0] beat_sel;
    logic                 in_accept;
    beat_t                in_beat;
    beat_t                out_beat;
    logic                 out_valid;
    logic                 sel_ready;
    logic [N_OUTPUTS-1:0] ready_vec;
    logic [N_OUTPUTS-1:0] valid_vec;

`ifdef AXIS_DEMUX_DEST_ROUTE_EN
    logic unused_address;
    assign unused_address = ^address;
    assign start_sel      = stream_in_dest[SEL_WIDTH-1:0];
`else
    assign start_sel = address;
`endif

    assign in_accept = stream_in_valid & stream_in_ready;

    // Packet lock: choose the select for this beat and track packet boundaries
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        beat_sel = (state_q == IDLE) ? start_sel : sel_q;
        if (in_accept) begin
            sel_d   = beat_sel;
            state_d = stream_in_tlast ? IDLE : IN_PKT;
        end
    end

    // FSM and held-select registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // Tag the incoming payload with its select
    always_comb begin
        in_beat.data  = stream_in_data;
        in_beat.dest  = stream_in_dest;
        in_beat.user  = stream_in_user;
        in_beat.tlast = stream_in_tlast;
        in_beat.sel   = beat_sel;
    end

    axi_stream_skid_buffer #(
        .beat_t (beat_t)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (stream_in_valid),
        .in_beat   (in_beat),
        .in_ready  (stream_in_ready),
        .out_valid (out_valid),
        .out_beat  (out_beat),
        .out_ready (sel_ready)
    );

    // Only the selected output's ready can drain the output register
    assign ready_vec = {stream_out_8_ready, stream_out_7_ready, stream_out_6_ready, stream_out_5_ready,
                        stream_out_4_ready, stream_out_3_ready, stream_out_2_ready, stream_out_1_ready};
    assign sel_ready = ready_vec[out_beat.sel];
    assign valid_vec = out_valid ? (N_OUTPUTS'(1) << out_beat.sel) : '0;

    assign {stream_out_8_valid, stream_out_7_valid, stream_out_6_valid, stream_out_5_valid,
            stream_out_4_valid, stream_out_3_valid, stream_out_2_valid, stream_out_1_valid} = valid_vec;

    // Payload is broadcast; only the valid is steered
    assign stream_out_1_data = out_beat.data;  assign stream_out_2_data = out_beat.data;
    assign stream_out_3_data = out_beat.data;  assign stream_out_4_data = out_beat.data;
    assign stream_out_5_data = out_beat.data;  assign stream_out_6_data = out_beat.data;
    assign stream_out_7_data = out_beat.data;  assign stream_out_8_data = out_beat.data;
    assign stream_out_1_dest = out_beat.dest;  assign stream_out_2_dest = out_beat.dest;
    assign stream_out_3_dest = out_beat.dest;  assign stream_out_4_dest = out_beat.dest;
    assign stream_out_5_dest = out_beat.dest;  assign stream_out_6_dest = out_beat.dest;
    assign stream_out_7_dest = out_beat.dest;  assign stream_out_8_dest = out_beat.dest;
    assign stream_out_1_user = out_beat.user;  assign stream_out_2_user = out_beat.user;
    assign stream_out_3_user = out_beat.user;  assign stream_out_4_user = out_beat.user;
    assign stream_out_5_user = out_beat.user;  assign stream_out_6_user = out_beat.user;
    assign stream_out_7_user = out_beat.user;  assign stream_out_8_user = out_beat.user;
    assign stream_out_1_tlast = out_beat.tlast; assign stream_out_2_tlast = out_beat.tlast;
    assign stream_out_3_tlast = out_beat.tlast; assign stream_out_4_tlast = out_beat.tlast;
    assign stream_out_5_tlast = out_beat.tlast; assign stream_out_6_tlast = out_beat.tlast;
    assign stream_out_7_tlast = out_beat.tlast; assign stream_out_8_tlast = out_beat.tlast;

    assign debug_state = state_q;

endmodule

// File: tb/tb_axi_stream_demux_8.sv
// Directed bench for axi_stream_demux_8: reset, packet lock, back-pressure,
// back-to-back packets, mid-packet reset and select source (address or dest).
module tb_axi_stream_demux_8;

  logic        clock;
  logic        reset;
  logic [2:0]  address;
  logic [15:0] in_data;
  logic [7:0]  in_dest;
  logic [7:0]  in_user;
  logic        in_tlast;
  logic        in_valid;
  wire         in_ready;
  wire  [15:0] o_data [8];
  wire  [7:0]  o_dest [8];
  wire  [7:0]  o_user [8];
  wire  [7:0]  o_tlast;
  wire  [7:0]  o_valid;
  logic [7:0]  o_ready;
  wire         debug_state;

  int checks = 0;
  int errors = 0;

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  axi_stream_demux_8 dut (
    .clock(clock), .reset(reset), .address(address),
    .stream_in_data(in_data), .stream_in_dest(in_dest), .stream_in_user(in_user),
    .stream_in_tlast(in_tlast), .stream_in_valid(in_valid), .stream_in_ready(in_ready),
    .stream_out_1_data(o_data[0]), .stream_out_2_data(o_data[1]), .stream_out_3_data(o_data[2]), .stream_out_4_data(o_data[3]),
    .stream_out_5_data(o_data[4]), .stream_out_6_data(o_data[5]), .stream_out_7_data(o_data[6]), .stream_out_8_data(o_data[7]),
    .stream_out_1_dest(o_dest[0]), .stream_out_2_dest(o_dest[1]), .stream_out_3_dest(o_dest[2]), .stream_out_4_dest(o_dest[3]),
    .stream_out_5_dest(o_dest[4]), .stream_out_6_dest(o_dest[5]), .stream_out_7_dest(o_dest[6]), .stream_out_8_dest(o_dest[7]),
    .stream_out_1_user(o_user[0]), .stream_out_2_user(o_user[1]), .stream_out_3_user(o_user[2]), .stream_out_4_user(o_user[3]),
    .stream_out_5_user(o_user[4]), .stream_out_6_user(o_user[5]), .stream_out_7_user(o_user[6]), .stream_out_8_user(o_user[7]),
    .stream_out_1_tlast(o_tlast[0]), .stream_out_2_tlast(o_tlast[1]), .stream_out_3_tlast(o_tlast[2]), .stream_out_4_tlast(o_tlast[3]),
    .stream_out_5_tlast(o_tlast[4]), .stream_out_6_tlast(o_tlast[5]), .stream_out_7_tlast(o_tlast[6]), .stream_out_8_tlast(o_tlast[7]),
    .stream_out_1_valid(o_valid[0]), .stream_out_2_valid(o_valid[1]), .stream_out_3_valid(o_valid[2]), .stream_out_4_valid(o_valid[3]),
    .stream_out_5_valid(o_valid[4]), .stream_out_6_valid(o_valid[5]), .stream_out_7_valid(o_valid[6]), .stream_out_8_valid(o_valid[7]),
    .stream_out_1_ready(o_ready[0]), .stream_out_2_ready(o_ready[1]), .stream_out_3_ready(o_ready[2]), .stream_out_4_ready(o_ready[3]),
    .stream_out_5_ready(o_ready[4]), .stream_out_6_ready(o_ready[5]), .stream_out_7_ready(o_ready[6]), .stream_out_8_ready(o_ready[7]),
    .debug_state(debug_state)
  );

  // one rising edge, then settle before sampling
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver: present one beat on the input
  task automatic drive(input logic [2:0] a, input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    address  = a;
    in_data  = d;
    in_tlast = last;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_tlast = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    address  = 3'd0;
    in_data  = 16'h0;
    in_dest  = 8'h0;
    in_user  = 8'h0;
    in_tlast = 1'b0;
    in_valid = 1'b0;
    o_ready  = 8'hFF;

    // reset state
    cyc();
    cyc();
    chk("rst_valid", {24'h0, o_valid}, 32'h0);
    chk("rst_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_data", {16'h0, o_data[0]}, 32'h0);
    chk("rst_tlast", {24'h0, o_tlast}, 32'h0);
    reset = 1'b0;
    cyc();
    chk("post_rst_ready", {31'h0, in_ready}, 32'h1);
    chk("post_rst_valid", {24'h0, o_valid}, 32'h0);

    // test 1: single beat to address 3 -> stream_out_4
    in_user = 8'hA5;
    drive(3'd3, 16'h00AA, 1'b1);
    cyc();
    chk("t1_valid", {24'h0, o_valid}, 32'h08);
    chk("t1_data", {16'h0, o_data[3]}, 32'h00AA);
    chk("t1_bcast", {16'h0, o_data[0]}, 32'h00AA);
    chk("t1_user", {24'h0, o_user[3]}, 32'hA5);
    chk("t1_ready", {31'h0, in_ready}, 32'h1);
    idle_in();
    cyc();
    chk("t1_drain", {24'h0, o_valid}, 32'h0);

    // test 2: 4-beat packet locked to address 1, address changes mid-packet
    drive(3'd1, 16'h0010, 1'b0);
    cyc();
    chk("t2_b0_valid", {24'h0, o_valid}, 32'h02);
    chk("t2_b0_data", {16'h0, o_data[1]}, 32'h0010);
    chk("t2_state", {31'h0, debug_state}, 32'h1);
    drive(3'd1, 16'h0011, 1'b0);
    cyc();
    chk("t2_b1_valid", {24'h0, o_valid}, 32'h02);
    chk("t2_b1_data", {16'h0, o_data[1]}, 32'h0011);
    drive(3'd6, 16'h0012, 1'b0);
    cyc();
    chk("t2_b2_valid", {24'h0, o_valid}, 32'h02);
    chk("t2_b2_data", {16'h0, o_data[1]}, 32'h0012);
    drive(3'd6, 16'h0013, 1'b1);
    cyc();
    chk("t2_b3_valid", {24'h0, o_valid}, 32'h02);
    chk("t2_b3_data", {16'h0, o_data[1]}, 32'h0013);
    chk("t2_b3_tlast", {31'h0, o_tlast[1]}, 32'h1);
    chk("t2_idle", {31'h0, debug_state}, 32'h0);
    drive(3'd6, 16'h0014, 1'b1);
    cyc();
    chk("t2_next_valid", {24'h0, o_valid}, 32'h40);
    chk("t2_next_data", {16'h0, o_data[6]}, 32'h0014);
    idle_in();
    cyc();
    chk("t2_drain", {24'h0, o_valid}, 32'h0);

    // test 3: back-pressure on stream_out_5, others ready (and ignored)
    o_ready[4] = 1'b0;
    drive(3'd4, 16'h0020, 1'b0);
    cyc();
    chk("t3_b0_valid", {24'h0, o_valid}, 32'h10);
    chk("t3_b0_data", {16'h0, o_data[4]}, 32'h0020);
    chk("t3_b0_ready", {31'h0, in_ready}, 32'h1);
    drive(3'd4, 16'h0021, 1'b0);
    cyc();
    chk("t3_skid_ready", {31'h0, in_ready}, 32'h0);
    chk("t3_hold1_data", {16'h0, o_data[4]}, 32'h0020);
    drive(3'd4, 16'h0022, 1'b1);
    cyc();
    chk("t3_hold2_ready", {31'h0, in_ready}, 32'h0);
    chk("t3_hold2_data", {16'h0, o_data[4]}, 32'h0020);
    chk("t3_hold2_valid", {24'h0, o_valid}, 32'h10);
    o_ready[4] = 1'b1;
    cyc();
    chk("t3_rel_data", {16'h0, o_data[4]}, 32'h0021);
    chk("t3_rel_valid", {24'h0, o_valid}, 32'h10);
    chk("t3_rel_ready", {31'h0, in_ready}, 32'h1);
    cyc();
    chk("t3_last_data", {16'h0, o_data[4]}, 32'h0022);
    chk("t3_last_tlast", {31'h0, o_tlast[4]}, 32'h1);
    idle_in();
    cyc();
    chk("t3_drain", {24'h0, o_valid}, 32'h0);

    // test 4: back-to-back single-beat packets to outputs 1 and 8
    drive(3'd0, 16'h0030, 1'b1);
    cyc();
    chk("t4_a_valid", {24'h0, o_valid}, 32'h01);
    chk("t4_a_data", {16'h0, o_data[0]}, 32'h0030);
    chk("t4_a_ready", {31'h0, in_ready}, 32'h1);
    drive(3'd7, 16'h0031, 1'b1);
    cyc();
    chk("t4_b_valid", {24'h0, o_valid}, 32'h80);
    chk("t4_b_data", {16'h0, o_data[7]}, 32'h0031);
    chk("t4_b_ready", {31'h0, in_ready}, 32'h1);
    idle_in();
    cyc();
    chk("t4_drain", {24'h0, o_valid}, 32'h0);

    // test 5: reset mid-packet with the output stalled
    o_ready[5] = 1'b0;
    drive(3'd5, 16'h0040, 1'b0);
    cyc();
    chk("t5_b0_valid", {24'h0, o_valid}, 32'h20);
    drive(3'd5, 16'h0041, 1'b0);
    cyc();
    chk("t5_skid_ready", {31'h0, in_ready}, 32'h0);
    drive(3'd5, 16'h0042, 1'b0);
    reset = 1'b1;
    cyc();
    chk("t5_rst_valid", {24'h0, o_valid}, 32'h0);
    chk("t5_rst_ready", {31'h0, in_ready}, 32'h0);
    chk("t5_rst_data", {16'h0, o_data[5]}, 32'h0);
    chk("t5_rst_state", {31'h0, debug_state}, 32'h0);
    reset = 1'b0;
    o_ready[5] = 1'b1;
    drive(3'd2, 16'h0050, 1'b1);
    cyc();
    chk("t5_rel_valid", {24'h0, o_valid}, 32'h0);
    chk("t5_rel_ready", {31'h0, in_ready}, 32'h1);
    cyc();
    chk("t5_new_valid", {24'h0, o_valid}, 32'h04);
    chk("t5_new_data", {16'h0, o_data[2]}, 32'h0050);
    idle_in();
    cyc();
    chk("t5_drain", {24'h0, o_valid}, 32'h0);

    // test 6: select source with address=0 and dest=0x05
    in_dest = 8'h05;
    drive(3'd0, 16'h0060, 1'b1);
    cyc();
`ifdef AXIS_DEMUX_DEST_ROUTE_EN
    chk("t6_valid", {24'h0, o_valid}, 32'h20);
    chk("t6_dest", {24'h0, o_dest[5]}, 32'h05);
    chk("t6_data", {16'h0, o_data[5]}, 32'h0060);
`else
    chk("t6_valid", {24'h0, o_valid}, 32'h01);
    chk("t6_dest", {24'h0, o_dest[0]}, 32'h05);
    chk("t6_data", {16'h0, o_data[0]}, 32'h0060);
`endif
    idle_in();
    cyc();
    chk("t6_drain", {24'h0, o_valid}, 32'h0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_stream_demux_8.md
Name: axi_stream_demux_8

Overview:
- 1:8 AXI-stream demultiplexer. Routes a single slave stream to one of eight master streams.
- Counterpart of the team's 8:1 stream mux. Used where one producer (ADC frontend, DMA) fans out to per-channel consumers.
- Packet-aware: the destination is locked for a whole packet, up to and including the tlast beat.
- Registered output with a skid buffer, giving full throughput and no combinational ready path from any output back to the input.

Parameters:
- DATA_WIDTH, 16, width of the data field on all streams.
- DEST_WIDTH, 8, width of the dest field.
- USER_WIDTH, 8, width of the user field.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- address  input  3  output select, 0 maps to stream_out_1 and 7 maps to stream_out_8. Sampled only at packet start.
- stream_in  axi_stream.slave  DATA_WIDTH+DEST_WIDTH+USER_WIDTH+3  input stream (data, dest, user, tlast, valid; ready driven).
- stream_out_1 .. stream_out_8  axi_stream.master  same width as stream_in  output streams.

Behaviour:
- One clock, `clock`. Reset is `reset`, synchronous, active-high.
- Reset state:
  - stream_in.ready=0.
  - All stream_out_N.valid=0; data/dest/user/tlast=0.
  - FSM=IDLE; skid buffer empty.
- stream_in.ready is a register.
  - It is 1 on the first cycle after reset release.
  - Thereafter ready = ~skid_valid.
- A beat is accepted when stream_in.valid & stream_in.ready.
- FSM states IDLE and IN_PKT:
  - IDLE: on an accepted beat, latch sel=address. If tlast=0 go to IN_PKT; if tlast=1 stay IDLE (single-beat packet).
  - IN_PKT: sel is held and address changes are ignored. The accepted beat with tlast=1 returns the FSM to IDLE.
  - The next packet's first beat may be accepted on the very next cycle, with a new sel.
- Each accepted beat is tagged with its sel. The tag travels with the beat through the skid and output registers.
- Output register:
  - Payload (data/dest/user/tlast) is broadcast to all eight outputs.
  - Only stream_out_(sel_o+1).valid is asserted; the other seven valids are 0.
  - The output register drains when the selected output's ready=1.
- Skid buffer:
  - If a beat is accepted while the output register is full and not draining, the beat goes to the skid register and ready drops on the next cycle.
  - When the output register drains, the skid content moves to it and ready returns to 1.
- Latency and throughput:
  - Latency is 1 cycle: a beat accepted at cycle N is valid on its output at N+1, when the output register is empty or draining at N.
  - Throughput is 1 beat/cycle while the selected output holds ready=1.
- AXI rules:
  - An asserted output valid is never withdrawn and its payload never changes until handshake.
  - Beat order is preserved, including across packet boundaries with different destinations.
- Output ready: readys of non-selected outputs are ignored. The ready of an output with valid=0 has no effect.
- Reset mid-packet: beats in the output and skid registers are discarded, the FSM returns to IDLE, and the next accepted beat is treated as packet start.

Optional Feature:
- Macro: AXIS_DEMUX_DEST_ROUTE_EN.
- When defined: the select is taken from stream_in.dest[2:0] of the first beat of each packet, and the address port is unused (left in the port list). dest is still forwarded unchanged.
- When undefined: the select comes from the address port as above.

Decomposition:
- Package axi_stream_demux_pkg holds:
  - N_OUTPUTS=8 and SEL_WIDTH=3.
  - The FSM enum typedef demux_state_t {IDLE, IN_PKT}.
  - A packed beat struct typedef (data, dest, user, tlast, sel).
- One sub-module: axi_stream_skid_buffer. It holds the two-entry output+skid register pair, carries the beat struct, and provides in_ready/out_valid/out_ready.

Test Plan:
1. Reset then single beats: address=3, beat data=0x00AA, tlast=1, all readys=1 -> stream_out_4.valid=1 at N+1 with data 0x00AA; the other valids stay 0; stream_in.ready stays 1.
2. Packet lock: address=1, 4-beat packet 0x10..0x13 with tlast on 0x13; address set to 6 after beat 2 -> all four beats on stream_out_2; the next packet goes to stream_out_7.
3. Back-pressure: stream_out_5.ready=0 for 3 cycles during a continuous stream to address 4 -> ready drops 1 cycle after the stall; exactly 2 beats are buffered; no loss or duplication; order 0x20,0x21,0x22 is preserved after release.
4. Back-to-back packets to different outputs: 1-beat packet to address 0 then 1-beat to address 7 on consecutive cycles -> stream_out_1 then stream_out_8 valid on consecutive cycles; ready=1 throughout.
5. Reset mid-packet: reset asserted after beat 2 of 5 with the output stalled -> all valids=0 and ready=0 during reset; after release the next beat with address=2 goes to stream_out_3.
6. With AXIS_DEMUX_DEST_ROUTE_EN: address=0, first beat dest=0x05 -> the packet goes to stream_out_6 with dest forwarded as 0x05.
